// File: rtl/arith_block_serial.sv
// arith_block_serial -- digit-serial adder/subtractor for the wide ALU datapath.
//
// One operand pair is accepted per in_valid/in_ready handshake. The block then
// adds DIGIT bits per clock, keeping the carry in a register between digits.
// The WIDTH-bit result, carry-out and flags are returned through an
// out_valid/out_ready handshake. The latency is NDIG = WIDTH/DIGIT cycles from
// the accepting edge to out_valid.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready input handshake for A, B, Cin, opsel
//   A, B [WIDTH]        operands
//   Cin                 external carry-in (used by opsel 111 only)
//   opsel [3]           000 ADD, 001 A+~B, 010 PASS A, 011 SUB,
//                       100 INC, 101 DEC, 110 A+B+1, 111 ADC
//   out_valid/out_ready output handshake
//   Result [WIDTH]      sum, held stable while out_valid is high
//   Cout                carry out of the MSB
//   Overflow, Zero      signed overflow, Result==0
//
// Optional flags: define ARITH_SERIAL_FLAGS_EN to build Overflow/Zero.
// Without it, both ports are tied to 0 and no flag registers exist.
module arith_block_serial #(
  parameter int WIDTH = 128,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [2:0]       opsel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("arith_block_serial: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [WIDTH-1:0] a_d, b_d, res_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q;

  // Operand conditioning: everything reduces to A + Beff + Ceff.
  logic [WIDTH-1:0] beff;
  logic             ceff;
  always_comb begin
    beff = B;
    ceff = 1'b0;
    case (opsel)
      3'b000: begin beff = B;        ceff = 1'b0; end
      3'b001: begin beff = ~B;       ceff = 1'b0; end
      3'b010: begin beff = '0;       ceff = 1'b0; end
      3'b011: begin beff = ~B;       ceff = 1'b1; end
      3'b100: begin beff = '0;       ceff = 1'b1; end
      3'b101: begin beff = '1;       ceff = 1'b0; end
      3'b110: begin beff = B;        ceff = 1'b1; end
      default: begin beff = B;       ceff = Cin;  end
    endcase
  end

  // Operands are shifted right one digit per cycle, so the adder always
  // works on the low digit and no wide variable part-select is needed.
  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic             c_dig;
  logic             last_dig;
  assign a_dig = a_q[DIGIT-1:0];
  assign b_dig = b_q[DIGIT-1:0];
  assign {c_dig, s_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
  assign last_dig = (cnt_q == CW'(NDIG - 1));

  // Result digits enter at the top and move down; after NDIG shifts digit 0
  // sits at the bottom.
  if (NDIG == 1) begin : g_one_digit
    assign a_d   = '0;
    assign b_d   = '0;
    assign res_d = s_dig;
  end else begin : g_multi_digit
    assign a_d   = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
    assign b_d   = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
    assign res_d = {s_dig, res_q[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          a_q     <= A;
          b_q     <= beff;
          carry_q <= ceff;
          cnt_q   <= '0;
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          a_q     <= a_d;
          b_q     <= b_d;
          res_q   <= res_d;
          carry_q <= c_dig;
          cnt_q   <= cnt_q + CW'(1);
          if (last_dig) begin
            cout_q  <= c_dig;
            state_q <= S_DONE;
          end
        end
        S_DONE: if (out_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Result    = res_q;
  assign Cout      = cout_q;

`ifdef ARITH_SERIAL_FLAGS_EN
  logic ovf_q, zero_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (state_q == S_IDLE && in_valid) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
    end else if (state_q == S_BUSY) begin
      zero_q <= zero_q & (s_dig == '0);
      // Carry into the MSB is recovered from the MSB sum bit.
      if (last_dig)
        ovf_q <= (a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ s_dig[DIGIT-1]) ^ c_dig;
    end
  end
  assign Overflow = ovf_q;
  assign Zero     = zero_q;
`else
  assign Overflow = 1'b0;
  assign Zero     = 1'b0;
`endif

endmodule

// File: tb/tb_arith_block_serial.sv
// Bench for arith_block_serial: a 128/8 instance and a 16/4 instance, driven
// with directed and random operations and checked against an arithmetic model.
module tb_arith_block_serial;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 128-bit / 8-bit-digit instance
  logic         iv_b, ir_b, ov_b, or_b, cin_b, co_b, ovf_b, z_b;
  logic [127:0] a_b, bb_b, r_b;
  logic [2:0]   op_b;
  // 16-bit / 4-bit-digit instance
  logic         iv_s, ir_s, ov_s, or_s, cin_s, co_s, ovf_s, z_s;
  logic [15:0]  a_s, bb_s, r_s;
  logic [2:0]   op_s;

  arith_block_serial #(.WIDTH(128), .DIGIT(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .A(a_b), .B(bb_b),
    .Cin(cin_b), .opsel(op_b), .out_valid(ov_b), .out_ready(or_b), .Result(r_b),
    .Cout(co_b), .Overflow(ovf_b), .Zero(z_b));

  arith_block_serial #(.WIDTH(16), .DIGIT(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir_s), .A(a_s), .B(bb_s),
    .Cin(cin_s), .opsel(op_s), .out_valid(ov_s), .out_ready(or_s), .Result(r_s),
    .Cout(co_s), .Overflow(ovf_s), .Zero(z_s));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: Result = A + Beff + Ceff on a w-bit machine.
  task automatic model(input int w, input logic [127:0] a, input logic [127:0] b,
                       input logic [2:0] op, input logic cin,
                       output logic [127:0] r, output logic co, output logic ov,
                       output logic z);
    logic [127:0] mask, beff;
    logic [128:0] sum;
    logic         ceff;
    mask = (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
    a = a & mask;
    b = b & mask;
    case (op)
      3'd0: begin beff = b;          ceff = 1'b0; end
      3'd1: begin beff = ~b & mask;  ceff = 1'b0; end
      3'd2: begin beff = '0;         ceff = 1'b0; end
      3'd3: begin beff = ~b & mask;  ceff = 1'b1; end
      3'd4: begin beff = '0;         ceff = 1'b1; end
      3'd5: begin beff = mask;       ceff = 1'b0; end
      3'd6: begin beff = b;          ceff = 1'b1; end
      default: begin beff = b;       ceff = cin;  end
    endcase
    sum = {1'b0, a} + {1'b0, beff} + {128'd0, ceff};
    r   = sum[127:0] & mask;
    co  = sum[w];
    // Signed overflow: operands of equal sign produce a result of the other sign.
    ov  = (a[w-1] == beff[w-1]) && (r[w-1] != a[w-1]);
    z   = (r == '0);
  endtask

  function automatic logic [127:0] res_of(input bit big);
    return big ? r_b : {112'd0, r_s};
  endfunction
  function automatic logic ovalid(input bit big); return big ? ov_b : ov_s; endfunction
  function automatic logic irdy(input bit big);   return big ? ir_b : ir_s; endfunction
  function automatic logic cout(input bit big);   return big ? co_b : co_s; endfunction
  function automatic logic oflow(input bit big);  return big ? ovf_b : ovf_s; endfunction
  function automatic logic zflag(input bit big);  return big ? z_b : z_s; endfunction

  task automatic drive_in(input bit big, input logic [127:0] a, input logic [127:0] b,
                          input logic [2:0] op, input logic cin);
    if (big) begin a_b = a; bb_b = b; op_b = op; cin_b = cin; iv_b = 1'b1; end
    else begin a_s = a[15:0]; bb_s = b[15:0]; op_s = op; cin_s = cin; iv_s = 1'b1; end
  endtask

  // Inputs are don't-care after capture, so scramble them.
  task automatic scramble(input bit big);
    if (big) begin
      iv_b = 1'b0; a_b = {$urandom, $urandom, $urandom, $urandom};
      bb_b = {$urandom, $urandom, $urandom, $urandom}; op_b = 3'($urandom); cin_b = 1'($urandom);
    end else begin
      iv_s = 1'b0; a_s = 16'($urandom); bb_s = 16'($urandom);
      op_s = 3'($urandom); cin_s = 1'($urandom);
    end
  endtask

  task automatic run_op(input bit big, input logic [127:0] a, input logic [127:0] b,
                        input logic [2:0] op, input logic cin, input int stall,
                        input bit lit_en, input logic [127:0] lit);
    logic [127:0] er;
    logic eco, eov, ez;
    int lat;
    int nd;
    nd = big ? 16 : 4;
    model(big ? 128 : 16, a, b, op, cin, er, eco, eov, ez);
`ifndef ARITH_SERIAL_FLAGS_EN
    eov = 1'b0;
    ez  = 1'b0;
`endif
    chk("in_ready_idle", 128'(irdy(big)), 128'd1);
    drive_in(big, a, b, op, cin);
    @(posedge clk); #1;
    scramble(big);
    chk("in_ready_busy", 128'(irdy(big)), 128'd0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ovalid(big) && lat < 100);
    chk("latency", 128'(lat), 128'(nd));
    chk("result", res_of(big), er);
    if (lit_en) chk("result_lit", res_of(big), lit);
    chk("cout", 128'(cout(big)), 128'(eco));
    chk("overflow", 128'(oflow(big)), 128'(eov));
    chk("zero", 128'(zflag(big)), 128'(ez));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_result", res_of(big), er);
      chk("stall_valid", 128'(ovalid(big)), 128'd1);
      chk("stall_in_ready", 128'(irdy(big)), 128'd0);
    end
    if (big) or_b = 1'b1; else or_s = 1'b1;
    @(posedge clk); #1;
    or_b = 1'b0; or_s = 1'b0;
    chk("valid_drop", 128'(ovalid(big)), 128'd0);
    chk("in_ready_back", 128'(irdy(big)), 128'd1);
  endtask

  typedef logic [15:0] lit16_t;
  lit16_t op_tab [8] = '{16'h1333, 16'h1134, 16'h1234, 16'h1135,
                         16'h1235, 16'h1233, 16'h1334, 16'h1334};
  logic [127:0] ones128;

  initial begin
    ones128 = {128{1'b1}};
    rst_n = 1'b0;
    iv_b = 0; or_b = 0; cin_b = 0; a_b = '0; bb_b = '0; op_b = '0;
    iv_s = 0; or_s = 0; cin_s = 0; a_s = '0; bb_s = '0; op_s = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_result_b", r_b, 128'd0);
    chk("rst_valid_b", 128'(ov_b), 128'd0);
    chk("rst_cout_b", 128'(co_b), 128'd0);
    chk("rst_flags_b", 128'({ovf_b, z_b}), 128'd0);
    chk("rst_ready_b", 128'(ir_b), 128'd1);
    chk("rst_result_s", 128'(r_s), 128'd0);
    chk("rst_ready_s", 128'(ir_s), 128'd1);
    @(posedge clk); #1;

    // Wide carry ripple through all 16 digits.
    run_op(1, ones128, 128'd1, 3'd0, 1'b0, 0, 1, 128'd0);
    // SUB boundary cases.
    run_op(0, 128'h5, 128'h7, 3'd3, 1'b0, 0, 1, 128'hFFFE);
    run_op(0, 128'h8000, 128'h1, 3'd3, 1'b0, 0, 1, 128'h7FFF);
    // Every opsel code.
    for (int k = 0; k < 8; k++)
      run_op(0, 128'h1234, 128'h00FF, 3'(k), 1'b1, 0, 1, 128'(op_tab[k]));
    // INC/DEC carry extremes.
    run_op(1, ones128, 128'd0, 3'd4, 1'b0, 0, 0, '0);
    run_op(1, 128'd0, 128'd0, 3'd5, 1'b0, 0, 0, '0);
    run_op(0, 128'd0, 128'd0, 3'd0, 1'b0, 0, 1, 128'd0);
    // Backpressure, then an immediately following op.
    run_op(0, 128'h7FFF, 128'h0001, 3'd0, 1'b0, 10, 0, '0);
    run_op(0, 128'hABCD, 128'h1111, 3'd6, 1'b0, 0, 0, '0);

    // Random traffic.
    for (int n = 0; n < 30; n++)
      run_op(0, 128'($urandom), 128'($urandom), 3'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), 0, '0);
    for (int n = 0; n < 8; n++)
      run_op(1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             3'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 0, '0);

    // Reset pulse in the middle of a 16-digit op with a live carry chain.
    drive_in(1, ones128, 128'd1, 3'd0, 1'b0);
    @(posedge clk); #1;
    scramble(1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_result", r_b, 128'd0);
    chk("midrst_valid", 128'(ov_b), 128'd0);
    chk("midrst_cout", 128'(co_b), 128'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", 128'(ir_b), 128'd1);
    chk("postrst_valid", 128'(ov_b), 128'd0);
    @(posedge clk); #1;
    run_op(1, 128'd0, 128'd0, 3'd0, 1'b0, 0, 1, 128'd0);
    run_op(1, 128'h1234_5678, 128'h9ABC_DEF0, 3'd3, 1'b0, 0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/arith_block_serial.md
Name: arith_block_serial

Overview:
- Parametrised, digit-serial successor to the 1-bit arithmetic slice, for the 128-bit ALU datapath.
- Accepts one operand pair plus an opsel code through a valid/ready handshake.
- Processes DIGIT bits per clock, holding the carry in a register between digits.
- Returns the WIDTH-bit result with carry-out and flags through an output valid/ready handshake. Trades latency for area versus a full-width adder.

Parameters:
- WIDTH, 128, operand/result width in bits.
- DIGIT, 8, bits processed per cycle. WIDTH % DIGIT must be 0, otherwise elaboration fails ($error). NDIG = WIDTH/DIGIT.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/opsel/cin valid
- in_ready  output  1  block can accept an operation
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  external carry-in, used only by opsel 111
- opsel  input  3  operation select
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- Result  output  WIDTH  arithmetic result
- Cout  output  1  carry out of the MSB
- Overflow  output  1  signed overflow (optional feature)
- Zero  output  1  Result == 0 (optional feature)

Behaviour:
Each operation is computed as Result = A + Beff + Ceff, where Beff and Ceff depend on opsel:
- 000 ADD: Beff = B, Ceff = 0
- 001 A+~B: Beff = ~B, Ceff = 0
- 010 PASS A: Beff = 0, Ceff = 0
- 011 SUB: Beff = ~B, Ceff = 1
- 100 INC: Beff = 0, Ceff = 1
- 101 DEC: Beff = all-ones, Ceff = 0
- 110 A+B+1: Beff = B, Ceff = 1
- 111 ADC: Beff = B, Ceff = Cin

State machine (IDLE, BUSY, DONE), with a digit counter of clog2(NDIG) bits:
- IDLE: in_ready = 1. On in_valid && in_ready, capture A, Beff and Ceff into internal registers, set counter = 0, and go to BUSY. Inputs are don't-care after capture.
- BUSY: in_ready = 0. Each edge adds digit k (bits k*DIGIT+DIGIT-1 : k*DIGIT) using the registered carry, writes that result digit, updates the carry, and increments k.
- After digit NDIG-1, go to DONE. out_valid asserts NDIG edges after the accepting edge (16 cycles at defaults).
- DONE: out_valid = 1, and Result/Cout/flags are held stable. On out_valid && out_ready, go to IDLE. in_ready returns to 1 on the following cycle, so there is no overlap of operations.
- Throughput: one operation per NDIG+2 cycles when out_ready is held high.
- out_ready low in DONE stalls indefinitely, with all outputs stable.
- Cout is the final carry. PASS gives Cout = 0. INC gives Cout = 1 only for A = all-ones. DEC gives Cout = 0 only for A = 0.
- Overflow = carry into the MSB XOR carry out of the MSB, captured while processing the last digit.
- DIGIT == WIDTH is legal: NDIG = 1 and latency is 1.

Reset:
- rst_n low at any time, including mid-BUSY or in DONE, forces the block to IDLE immediately.
- Reset values: out_valid 0, Result 0, Cout 0, Overflow 0, Zero 0, counter 0, carry 0.
- in_ready reads 1 once rst_n is high. Any in-flight operation is discarded.

Optional Feature:
- Macro: ARITH_SERIAL_FLAGS_EN.
- Defined: Overflow and Zero are computed as above. Zero is accumulated per digit by ANDing "digit == 0" flags, and is valid in DONE.
- Undefined: Overflow and Zero are tied to 0, and the flag logic and its registers are not built. Ports remain present.

Test Plan:
- WIDTH=128, DIGIT=8, ADD, A=2^128-1, B=1 -> after 16 cycles out_valid=1, Result=0, Cout=1, Zero=1, Overflow=0.
- WIDTH=16, DIGIT=4, SUB, A=0x0005, B=0x0007 -> Result=0xFFFE, Cout=0, Overflow=0. SUB, A=0x8000, B=0x0001 -> Result=0x7FFF, Cout=1, Overflow=1.
- WIDTH=16, DIGIT=4, all eight opsel codes with A=0x1234, B=0x00FF, Cin=1 -> Result = 0x1333, 0x1134, 0x1234, 0x1135, 0x1235, 0x1233, 0x1334, 0x1334 respectively.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> Result stable and in_ready=0. Raise out_ready -> out_valid drops the next cycle and in_ready=1; a second in_valid is accepted and no op is lost or duplicated.
- Pulse rst_n low for 1 cycle at digit 5 of a 16-digit op -> outputs zero, IDLE, in_ready=1. A new op completes correctly with no stale carry.
- Build without ARITH_SERIAL_FLAGS_EN, ADD A=0, B=0 -> Result=0, Zero=0, Overflow=0.
